// File: rtl/version_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : version_store_ctrl
// Brief    : Four-slot multi-version store controller. Assigns increasing
//            versions to writes, round-robin arbitrates one writer and two
//            readers, and resolves each read with a four-cycle slot scan
//            returning the newest version strictly older than requested.
// Options  : VSTORE_MISS_ZERO_EN - zero rdData/rdHitVersion on a read miss.
// Revision : 1.0 - initial release
// ============================================================================
module version_store_ctrl #(
   parameter int VER_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              storeClr,
   input  logic              wrValid,
   output logic              wrReady,
   input  logic [DATA_W-1:0] wrData,
   output logic [VER_W-1:0]  wrVersion,
   input  logic              rdReq0,
   input  logic              rdReq1,
   input  logic [VER_W-1:0]  rdVersion0,
   input  logic [VER_W-1:0]  rdVersion1,
   output logic              rdGnt0,
   output logic              rdGnt1,
   output logic              rdRespValid0,
   output logic              rdRespValid1,
   output logic              rdHit,
   output logic [VER_W-1:0]  rdHitVersion,
   output logic [DATA_W-1:0] rdData,
   output logic              storeFull
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [VER_W-1:0] C_VER_MAX = {VER_W{1'b1}};

   state_t              state_q, state_d;
   logic [1:0]          prio_q, prio_d;       // 0 = wr, 1 = rd0, 2 = rd1 first
   logic [1:0]          wr_ptr_q, wr_ptr_d;
   logic [VER_W-1:0]    next_ver_q, next_ver_d;
   logic                store_full_q, store_full_d;
   logic [3:0]          slot_valid_q, slot_valid_d;
   logic [VER_W-1:0]    slot_ver_q [4];
   logic [VER_W-1:0]    slot_ver_d [4];
   logic [DATA_W-1:0]   slot_data_q [4];
   logic [DATA_W-1:0]   slot_data_d [4];
   logic [1:0]          idx_q, idx_d;
   logic                req_id_q, req_id_d;   // 0 = rd0, 1 = rd1
   logic [VER_W-1:0]    req_ver_q, req_ver_d;
   logic                best_valid_q, best_valid_d;
   logic [VER_W-1:0]    best_ver_q, best_ver_d;
   logic [DATA_W-1:0]   best_data_q, best_data_d;
   logic                hit_q, hit_d;
   logic [VER_W-1:0]    hit_ver_q, hit_ver_d;
   logic [DATA_W-1:0]   data_q, data_d;

   logic [2:0]          cand;                 // {rd1, rd0, wr}
   logic [2:0]          gnt;
   logic                grant_en;
   logic                qualify;
   logic                nb_valid;
   logic [VER_W-1:0]    nb_ver;
   logic [DATA_W-1:0]   nb_data;

   // Round-robin arbiter: scan candidates cyclically starting at prio_q.
   always_comb begin
      cand     = {rdReq1, rdReq0, wrValid & ~store_full_q};
      grant_en = (state_q == ST_IDLE) && !storeClr && !rst;
      gnt      = 3'b000;
      case (prio_q)
         2'd1: begin
            if      (cand[1]) gnt = 3'b010;
            else if (cand[2]) gnt = 3'b100;
            else if (cand[0]) gnt = 3'b001;
         end
         2'd2: begin
            if      (cand[2]) gnt = 3'b100;
            else if (cand[0]) gnt = 3'b001;
            else if (cand[1]) gnt = 3'b010;
         end
         default: begin
            if      (cand[0]) gnt = 3'b001;
            else if (cand[1]) gnt = 3'b010;
            else if (cand[2]) gnt = 3'b100;
         end
      endcase
      if (!grant_en) begin
         gnt = 3'b000;
      end
   end

   // Scan step: fold slot[idx] into the best-so-far candidate.
   always_comb begin
      qualify  = slot_valid_q[idx_q] && (slot_ver_q[idx_q] < req_ver_q) &&
                 (!best_valid_q || (slot_ver_q[idx_q] > best_ver_q));
      nb_valid = best_valid_q;
      nb_ver   = best_ver_q;
      nb_data  = best_data_q;
      if (qualify) begin
         nb_valid = 1'b1;
         nb_ver   = slot_ver_q[idx_q];
         nb_data  = slot_data_q[idx_q];
      end
   end

   // Next-state logic for the FSM, the store and the read result registers.
   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      wr_ptr_d     = wr_ptr_q;
      next_ver_d   = next_ver_q;
      store_full_d = store_full_q;
      slot_valid_d = slot_valid_q;
      slot_ver_d   = slot_ver_q;
      slot_data_d  = slot_data_q;
      idx_d        = idx_q;
      req_id_d     = req_id_q;
      req_ver_d    = req_ver_q;
      best_valid_d = best_valid_q;
      best_ver_d   = best_ver_q;
      best_data_d  = best_data_q;
      hit_d        = hit_q;
      hit_ver_d    = hit_ver_q;
      data_d       = data_q;

      if (gnt[0]) prio_d = 2'd1;
      if (gnt[1]) prio_d = 2'd2;
      if (gnt[2]) prio_d = 2'd0;

      if (storeClr) begin
         // Clear wipes the store and aborts any read in flight.
         slot_valid_d = 4'b0000;
         wr_ptr_d     = 2'd0;
         next_ver_d   = '0;
         store_full_d = 1'b0;
         state_d      = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt[0]) begin
                  slot_valid_d[wr_ptr_q] = 1'b1;
                  slot_ver_d[wr_ptr_q]   = next_ver_q;
                  slot_data_d[wr_ptr_q]  = wrData;
                  wr_ptr_d               = wr_ptr_q + 2'd1;
                  if (next_ver_q == C_VER_MAX) begin
                     store_full_d = 1'b1;
                  end else begin
                     next_ver_d = next_ver_q + 1'b1;
                  end
               end else if (gnt[1] || gnt[2]) begin
                  req_id_d     = gnt[2];
                  req_ver_d    = gnt[2] ? rdVersion1 : rdVersion0;
                  best_valid_d = 1'b0;
                  best_ver_d   = '0;
                  best_data_d  = '0;
                  idx_d        = 2'd0;
                  state_d      = ST_SCAN;
               end
            end
            ST_SCAN: begin
               best_valid_d = nb_valid;
               best_ver_d   = nb_ver;
               best_data_d  = nb_data;
               idx_d        = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  hit_d = nb_valid;
                  if (nb_valid) begin
                     hit_ver_d = nb_ver;
                     data_d    = nb_data;
                  end else begin
`ifdef VSTORE_MISS_ZERO_EN
                     hit_ver_d = '0;
                     data_d    = '0;
`else
                     hit_ver_d = hit_ver_q;
                     data_d    = data_q;
`endif
                  end
                  state_d = ST_RESP;
               end
            end
            ST_RESP: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and data registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         prio_q       <= 2'd0;
         wr_ptr_q     <= 2'd0;
         next_ver_q   <= '0;
         store_full_q <= 1'b0;
         slot_valid_q <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            slot_ver_q[i]  <= '0;
            slot_data_q[i] <= '0;
         end
         idx_q        <= 2'd0;
         req_id_q     <= 1'b0;
         req_ver_q    <= '0;
         best_valid_q <= 1'b0;
         best_ver_q   <= '0;
         best_data_q  <= '0;
         hit_q        <= 1'b0;
         hit_ver_q    <= '0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         wr_ptr_q     <= wr_ptr_d;
         next_ver_q   <= next_ver_d;
         store_full_q <= store_full_d;
         slot_valid_q <= slot_valid_d;
         slot_ver_q   <= slot_ver_d;
         slot_data_q  <= slot_data_d;
         idx_q        <= idx_d;
         req_id_q     <= req_id_d;
         req_ver_q    <= req_ver_d;
         best_valid_q <= best_valid_d;
         best_ver_q   <= best_ver_d;
         best_data_q  <= best_data_d;
         hit_q        <= hit_d;
         hit_ver_q    <= hit_ver_d;
         data_q       <= data_d;
      end
   end

   // Output mapping; the response pulse is suppressed when a clear aborts it.
   always_comb begin
      wrReady      = gnt[0];
      rdGnt0       = gnt[1];
      rdGnt1       = gnt[2];
      rdRespValid0 = (state_q == ST_RESP) && !req_id_q && !storeClr && !rst;
      rdRespValid1 = (state_q == ST_RESP) &&  req_id_q && !storeClr && !rst;
      rdHit        = hit_q;
      rdHitVersion = hit_ver_q;
      rdData       = data_q;
      storeFull    = store_full_q;
      wrVersion    = next_ver_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_version_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_version_store_ctrl
// Brief    : Directed self-checking bench for version_store_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_version_store_ctrl;

   logic        clk = 1'b0;
   logic        rst, storeClr, wrValid, wrReady;
   logic [31:0] wrData;
   logic [3:0]  wrVersion;
   logic        rdReq0, rdReq1, rdGnt0, rdGnt1, rdRespValid0, rdRespValid1;
   logic [3:0]  rdVersion0, rdVersion1, rdHitVersion;
   logic        rdHit, storeFull;
   logic [31:0] rdData;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   version_store_ctrl #(.VER_W(4), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .storeClr(storeClr),
      .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData), .wrVersion(wrVersion),
      .rdReq0(rdReq0), .rdReq1(rdReq1), .rdVersion0(rdVersion0), .rdVersion1(rdVersion1),
      .rdGnt0(rdGnt0), .rdGnt1(rdGnt1),
      .rdRespValid0(rdRespValid0), .rdRespValid1(rdRespValid1),
      .rdHit(rdHit), .rdHitVersion(rdHitVersion), .rdData(rdData),
      .storeFull(storeFull)
   );

   // Stimulus: one write, expected to be granted immediately from IDLE.
   task automatic do_write(input logic [31:0] d);
      @(negedge clk);
      wrValid = 1'b1;
      wrData  = d;
      #1;
      total++;
      if (wrReady !== 1'b1) begin
         bad++;
         $display("FAIL write_grant data=%h got=%b exp=1", d, wrReady);
      end
      @(posedge clk);
      #1;
      wrValid = 1'b0;
   endtask

   // Stimulus: one read; returns latency (posedges after accept) and results.
   task automatic do_read(input bit port, input logic [3:0] ver, output int lat,
                          output logic hit, output logic [3:0] hv, output logic [31:0] dat);
      lat = -1; hit = 1'b0; hv = '0; dat = '0;
      @(negedge clk);
      if (!port) begin rdReq0 = 1'b1; rdVersion0 = ver; end
      else       begin rdReq1 = 1'b1; rdVersion1 = ver; end
      #1;
      total++;
      if ((port ? rdGnt1 : rdGnt0) !== 1'b1) begin
         bad++;
         $display("FAIL read_grant port=%0d got=%b exp=1", port, port ? rdGnt1 : rdGnt0);
      end
      @(posedge clk);
      #1;
      rdReq0 = 1'b0;
      rdReq1 = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         #1;
         if ((port ? rdRespValid1 : rdRespValid0) === 1'b1) begin
            lat = n; hit = rdHit; hv = rdHitVersion; dat = rdData;
            break;
         end
      end
      total++;
      if (lat < 0) begin
         bad++;
         $display("FAIL read_timeout port=%0d got=no_response exp=response", port);
      end else begin
         @(posedge clk);
         #1;
         if ((port ? rdRespValid1 : rdRespValid0) !== 1'b0) begin
            bad++;
            $display("FAIL resp_pulse_width port=%0d got=1 exp=0", port);
         end
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      storeClr = 1'b1;
      @(negedge clk);
      storeClr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; storeClr = 1'b0; wrValid = 1'b0; wrData = '0;
      rdReq0 = 1'b0; rdReq1 = 1'b0; rdVersion0 = '0; rdVersion1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({wrReady, rdGnt0, rdGnt1, rdRespValid0, rdRespValid1, rdHit, storeFull} !== 7'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=0000000",
                  {wrReady, rdGnt0, rdGnt1, rdRespValid0, rdRespValid1, rdHit, storeFull});
      end
      total++;
      if ({rdHitVersion, rdData, wrVersion} !== 40'h0) begin
         bad++;
         $display("FAIL reset_values got=%h exp=0", {rdHitVersion, rdData, wrVersion});
      end
   endtask

   task automatic test_basic_hit();
      int lat; logic hit; logic [3:0] hv; logic [31:0] dat;
      do_write(32'hA0);
      do_write(32'hA1);
      do_write(32'hA2);
      total++;
      if (wrVersion !== 4'd3) begin
         bad++;
         $display("FAIL basic_next_version got=%0d exp=3", wrVersion);
      end
      do_read(1'b0, 4'd2, lat, hit, hv, dat);
      total++;
      if (lat != 4 || hit !== 1'b1 || hv !== 4'd1 || dat !== 32'hA1) begin
         bad++;
         $display("FAIL basic_hit got lat=%0d hit=%b ver=%0d data=%h exp lat=4 hit=1 ver=1 data=a1",
                  lat, hit, hv, dat);
      end
   endtask

   task automatic test_miss();
      int lat; logic hit; logic [3:0] hv; logic [31:0] dat;
      logic [3:0] ev; logic [31:0] ed;
`ifdef VSTORE_MISS_ZERO_EN
      ev = 4'd0; ed = 32'h0;
`else
      ev = 4'd1; ed = 32'hA1;
`endif
      do_read(1'b1, 4'd0, lat, hit, hv, dat);
      total++;
      if (lat != 4 || hit !== 1'b0 || hv !== ev || dat !== ed) begin
         bad++;
         $display("FAIL miss_ver0 got lat=%0d hit=%b ver=%0d data=%h exp lat=4 hit=0 ver=%0d data=%h",
                  lat, hit, hv, dat, ev, ed);
      end
   endtask

   task automatic test_arbitration();
      // Grant vector {rd1, rd0, wr} per cycle; pattern repeats every 13 cycles.
      logic [2:0] exp_g [13];
      logic [1:0] exp_r [13];
      for (int i = 0; i < 13; i++) begin exp_g[i] = 3'b000; exp_r[i] = 2'b00; end
      exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[7] = 3'b100;
      exp_r[6] = 2'b01;  exp_r[12] = 2'b10;
      @(negedge clk);
      rst = 1'b1; wrValid = 1'b1; wrData = 32'hE0;
      rdReq0 = 1'b1; rdReq1 = 1'b1; rdVersion0 = 4'd5; rdVersion1 = 4'd5;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 26; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if ({rdGnt1, rdGnt0, wrReady} !== exp_g[c % 13] ||
             {rdRespValid1, rdRespValid0} !== exp_r[c % 13]) begin
            bad++;
            $display("FAIL arb_cycle%0d got gnt=%b resp=%b exp gnt=%b resp=%b", c,
                     {rdGnt1, rdGnt0, wrReady}, {rdRespValid1, rdRespValid0},
                     exp_g[c % 13], exp_r[c % 13]);
         end
      end
      wrValid = 1'b0; rdReq0 = 1'b0; rdReq1 = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_wrap();
      int lat; logic hit; logic [3:0] hv; logic [31:0] dat;
      do_clear();
      total++;
      if (wrVersion !== 4'd0) begin
         bad++;
         $display("FAIL wrap_clear_version got=%0d exp=0", wrVersion);
      end
      for (int i = 0; i < 6; i++) do_write(32'hB0 + i);
      do_read(1'b0, 4'd1, lat, hit, hv, dat);
      total++;
      if (lat != 4 || hit !== 1'b0) begin
         bad++;
         $display("FAIL wrap_evicted got lat=%0d hit=%b exp lat=4 hit=0", lat, hit);
      end
      do_read(1'b1, 4'd15, lat, hit, hv, dat);
      total++;
      if (hit !== 1'b1 || hv !== 4'd5 || dat !== 32'hB5) begin
         bad++;
         $display("FAIL wrap_newest got hit=%b ver=%0d data=%h exp hit=1 ver=5 data=b5", hit, hv, dat);
      end
      do_read(1'b0, 4'd4, lat, hit, hv, dat);
      total++;
      if (hit !== 1'b1 || hv !== 4'd3 || dat !== 32'hB3) begin
         bad++;
         $display("FAIL wrap_strict got hit=%b ver=%0d data=%h exp hit=1 ver=3 data=b3", hit, hv, dat);
      end
   endtask

   task automatic test_full();
      int lat; logic hit; logic [3:0] hv; logic [31:0] dat;
      logic rdy_seen;
      do_clear();
      for (int i = 0; i < 15; i++) do_write(32'hC0 + i);
      total++;
      if (storeFull !== 1'b0 || wrVersion !== 4'd15) begin
         bad++;
         $display("FAIL full_before got full=%b ver=%0d exp full=0 ver=15", storeFull, wrVersion);
      end
      do_write(32'hCF);
      total++;
      if (storeFull !== 1'b1 || wrVersion !== 4'd15) begin
         bad++;
         $display("FAIL full_after got full=%b ver=%0d exp full=1 ver=15", storeFull, wrVersion);
      end
      rdy_seen = 1'b0;
      @(negedge clk);
      wrValid = 1'b1; wrData = 32'hFF;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (wrReady !== 1'b0) rdy_seen = 1'b1;
         @(negedge clk);
      end
      wrValid = 1'b0;
      total++;
      if (rdy_seen !== 1'b0 || storeFull !== 1'b1) begin
         bad++;
         $display("FAIL full_refuse got ready_seen=%b full=%b exp ready_seen=0 full=1", rdy_seen, storeFull);
      end
      do_read(1'b1, 4'd15, lat, hit, hv, dat);
      total++;
      if (hit !== 1'b1 || hv !== 4'd14 || dat !== 32'hCE) begin
         bad++;
         $display("FAIL full_read got hit=%b ver=%0d data=%h exp hit=1 ver=14 data=ce", hit, hv, dat);
      end
      do_clear();
      total++;
      if (storeFull !== 1'b0 || wrVersion !== 4'd0) begin
         bad++;
         $display("FAIL full_clear got full=%b ver=%0d exp full=0 ver=0", storeFull, wrVersion);
      end
      do_write(32'hD0);
      do_read(1'b0, 4'd1, lat, hit, hv, dat);
      total++;
      if (hit !== 1'b1 || hv !== 4'd0 || dat !== 32'hD0 || wrVersion !== 4'd1) begin
         bad++;
         $display("FAIL full_restart got hit=%b ver=%0d data=%h next=%0d exp hit=1 ver=0 data=d0 next=1",
                  hit, hv, dat, wrVersion);
      end
   endtask

   task automatic test_abort();
      int lat;
      logic pulse0_seen;
      pulse0_seen = 1'b0;
      lat = -1;
      @(negedge clk);
      rdReq0 = 1'b1; rdVersion0 = 4'd1;
      @(posedge clk);            // accept
      #1;
      rdReq0 = 1'b0;
      @(posedge clk);            // now in the second scan cycle
      #1;
      storeClr = 1'b1;
      rdReq1 = 1'b1; rdVersion1 = 4'd15;
      #1;
      total++;
      if ({rdGnt1, rdGnt0, wrReady, rdRespValid0} !== 4'b0000) begin
         bad++;
         $display("FAIL abort_grants got=%b exp=0000", {rdGnt1, rdGnt0, wrReady, rdRespValid0});
      end
      @(posedge clk);
      #1;
      storeClr = 1'b0;
      #1;
      total++;
      if (rdGnt1 !== 1'b1 || rdRespValid0 !== 1'b0) begin
         bad++;
         $display("FAIL abort_idle got gnt1=%b resp0=%b exp gnt1=1 resp0=0", rdGnt1, rdRespValid0);
      end
      @(posedge clk);
      #1;
      rdReq1 = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         #1;
         if (rdRespValid0 === 1'b1) pulse0_seen = 1'b1;
         if (rdRespValid1 === 1'b1 && lat < 0) lat = n;
      end
      total++;
      if (pulse0_seen !== 1'b0 || lat != 4 || rdHit !== 1'b0 || wrVersion !== 4'd0) begin
         bad++;
         $display("FAIL abort_after got resp0_seen=%b lat=%0d hit=%b next=%0d exp resp0_seen=0 lat=4 hit=0 next=0",
                  pulse0_seen, lat, rdHit, wrVersion);
      end
   endtask

   initial begin
      test_reset();
      test_basic_hit();
      test_miss();
      test_arbitration();
      test_wrap();
      test_full();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
